// File: rtl/knn_pkg.sv
// Shared constants and types for the k-NN query feeder (upstream stage of dist_sort).
//   DATA_W    : width of a query and of each search vector
//   NUM_SV    : number of search vectors in a bank
//   SV_ADDR_W : width of a search-vector index
//   sv_t      : one query / search vector
//   feed_state_e : feeder FSM states (LOAD, RUN, DRAIN)
package knn_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned NUM_SV    = 8;
  localparam int unsigned SV_ADDR_W = $clog2(NUM_SV);

  typedef logic [DATA_W-1:0] sv_t;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DRAIN
  } feed_state_e;

endpackage

// File: rtl/knn_query_fifo.sv
// Synchronous query FIFO with full/empty flags and an occupancy count.
// Reads are non-registered: rdata always shows the head entry.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata  : write wdata when push && !full
//   pop          : drop the head entry when pop && !empty
//   rdata        : head entry
//   full, empty  : occupancy flags
//   count        : number of stored entries (0..DEPTH)
module knn_query_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra wrap bit on each pointer distinguishes full from empty.
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/knn_query_feeder.sv
// k-NN query feeder: holds the search-vector bank and streams buffered queries into dist_sort.
// Search vectors are written over sv_wr_*; sv_commit starts streaming, sv_reload drains the
// query FIFO and returns to loading. One queued query is issued per cycle in RUN/DRAIN.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   sv_wr_en/addr/data       : search-vector write
//   sv_commit, sv_reload     : single-cycle commands (reload has precedence)
//   q_valid, q_data, q_ready : query input handshake (q_ready is registered)
//   query, search_0..7       : to dist_sort, valid while in_valid
//   in_valid                 : to dist_sort, no backpressure
//   state_run                : high while in RUN
//   cmd_err                  : one-cycle pulse after an illegal write or command
//   issued_cnt               : queries issued since reset, wrapping
// Build option SHADOW_BANK_EN: writes go to a shadow bank (any state) that sv_commit copies
// into the active bank when the shadow bank is fully loaded.
module knn_query_feeder
  import knn_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sv_wr_en,
  input  logic [SV_ADDR_W-1:0] sv_wr_addr,
  input  sv_t                  sv_wr_data,
  input  logic                 sv_commit,
  input  logic                 sv_reload,
  input  logic                 q_valid,
  input  sv_t                  q_data,
  output logic                 q_ready,
  output sv_t                  query,
  output sv_t                  search_0,
  output sv_t                  search_1,
  output sv_t                  search_2,
  output sv_t                  search_3,
  output sv_t                  search_4,
  output sv_t                  search_5,
  output sv_t                  search_6,
  output sv_t                  search_7,
  output logic                 in_valid,
  output logic                 state_run,
  output logic                 cmd_err,
  output logic [CNT_W-1:0]     issued_cnt
);

  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

  feed_state_e       state_q, state_d;
  sv_t               bank_q [NUM_SV];
  sv_t               srch_q [NUM_SV];
  logic [NUM_SV-1:0] mask_q, mask_d;
  sv_t               query_q;
  logic              in_valid_q, q_ready_q, q_ready_d, cmd_err_q;
  logic [CNT_W-1:0]  issued_q;

  logic              push, pop;
  sv_t               fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

  logic              err, wr_err, act_wr, copy_shadow, mask_clr;
  int                count_nxt;

  // ---------------------------------------------------------------------------
  // Query FIFO
  // ---------------------------------------------------------------------------
  assign push = q_valid && q_ready_q;
  assign pop  = (state_q != LOAD) && !fifo_empty;

  knn_query_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (q_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Optional shadow bank
  // ---------------------------------------------------------------------------
`ifdef SHADOW_BANK_EN
  sv_t               shadow_q [NUM_SV];
  logic [NUM_SV-1:0] shadow_mask_q;

  assign act_wr = 1'b0;
  assign wr_err = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SV); i++) shadow_q[i] <= '0;
      shadow_mask_q <= '0;
    end else begin
      if (copy_shadow) shadow_mask_q <= '0;
      if (sv_wr_en) begin
        shadow_q[sv_wr_addr]      <= sv_wr_data;
        shadow_mask_q[sv_wr_addr] <= 1'b1;
      end
    end
  end
`else
  assign act_wr = sv_wr_en && (state_q == LOAD);
  assign wr_err = sv_wr_en && (state_q != LOAD);
`endif

  // ---------------------------------------------------------------------------
  // FSM next state and command checking
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    err         = wr_err;
    copy_shadow = 1'b0;
    mask_clr    = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (sv_reload) begin
          err = 1'b1;
        end else if (sv_commit) begin
`ifdef SHADOW_BANK_EN
          if (&shadow_mask_q) begin
            copy_shadow = 1'b1;
            state_d     = RUN;
          end else if (&mask_q) begin
            state_d = RUN;
          end else begin
            err = 1'b1;
          end
`else
          if (&mask_q) state_d = RUN;
          else         err     = 1'b1;
`endif
        end
      end
      RUN: begin
        if (sv_reload) begin
          state_d = DRAIN;
          // A commit alongside a reload is dropped and flagged.
          if (sv_commit) err = 1'b1;
        end else if (sv_commit) begin
`ifdef SHADOW_BANK_EN
          if (&shadow_mask_q) copy_shadow = 1'b1;
          else                err         = 1'b1;
`else
          err = 1'b1;
`endif
        end
      end
      DRAIN: begin
        if (sv_reload || sv_commit) err = 1'b1;
        if (fifo_empty) begin
          state_d  = LOAD;
          mask_clr = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    if (mask_clr)    mask_d = '0;
    if (copy_shadow) mask_d = '1;
    if (act_wr)      mask_d[sv_wr_addr] = 1'b1;
  end

  // q_ready is registered, so it is derived from next-cycle FIFO occupancy.
  always_comb begin
    count_nxt = int'(fifo_count) + int'(push) - int'(pop);
    q_ready_d = (state_d == RUN) && (count_nxt < int'(FIFO_DEPTH));
  end

  // ---------------------------------------------------------------------------
  // State, bank and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      mask_q     <= '0;
      query_q    <= '0;
      in_valid_q <= 1'b0;
      q_ready_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
      issued_q   <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      in_valid_q <= pop;
      q_ready_q  <= q_ready_d;
      cmd_err_q  <= err;
      if (pop) begin
        query_q  <= fifo_rdata;
        issued_q <= issued_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SV); i++) bank_q[i] <= '0;
    end else begin
`ifdef SHADOW_BANK_EN
      if (copy_shadow) begin
        for (int i = 0; i < int'(NUM_SV); i++) bank_q[i] <= shadow_q[i];
      end
`else
      if (act_wr) bank_q[sv_wr_addr] <= sv_wr_data;
`endif
    end
  end

  // search_* are snapshotted with each issued query, so they stay tied to that query even if
  // the active bank changes in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SV); i++) srch_q[i] <= '0;
    end else if (pop) begin
      for (int i = 0; i < int'(NUM_SV); i++) srch_q[i] <= bank_q[i];
    end
  end

  assign q_ready    = q_ready_q;
  assign query      = query_q;
  assign in_valid   = in_valid_q;
  assign state_run  = (state_q == RUN);
  assign cmd_err    = cmd_err_q;
  assign issued_cnt = issued_q;

  assign search_0 = srch_q[0];
  assign search_1 = srch_q[1];
  assign search_2 = srch_q[2];
  assign search_3 = srch_q[3];
  assign search_4 = srch_q[4];
  assign search_5 = srch_q[5];
  assign search_6 = srch_q[6];
  assign search_7 = srch_q[7];

endmodule

// File: tb/tb_knn_query_feeder.sv
// Self-checking bench for knn_query_feeder: a command table exercising the LOAD/RUN FSM,
// followed by hand-written streaming, drain, reset and (with SHADOW_BANK_EN) shadow sequences.
// Issued queries are checked against a scoreboard filled on each accepted handshake.
module tb_knn_query_feeder;
  import knn_pkg::*;

  localparam int unsigned CNT_W = 16;
`ifdef SHADOW_BANK_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  typedef logic [575:0] wide_t;
  typedef logic [NUM_SV-1:0][DATA_W-1:0] bank_t;
  typedef struct packed {
    sv_t   q;
    bank_t srch;
  } exp_t;
  typedef struct packed {
    logic                 wr;
    logic [SV_ADDR_W-1:0] addr;
    sv_t                  data;
    logic                 commit;
    logic                 reload;
    logic                 e_run;
    logic                 e_err;
    logic                 e_rdy;
  } cmd_vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sv_wr_en, sv_commit, sv_reload, q_valid;
  logic [SV_ADDR_W-1:0] sv_wr_addr;
  sv_t                  sv_wr_data, q_data;
  logic                 q_ready, in_valid, state_run, cmd_err;
  sv_t                  query;
  sv_t                  search_0, search_1, search_2, search_3;
  sv_t                  search_4, search_5, search_6, search_7;
  logic [CNT_W-1:0]     issued_cnt;
  bank_t                dut_srch;

  bank_t    model_bank;
  exp_t     sb[$];
  cmd_vec_t tbl[15];
  int       n_vec = 0;
  int       n_err = 0;

  knn_query_feeder #(
    .FIFO_DEPTH (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sv_wr_en   (sv_wr_en),
    .sv_wr_addr (sv_wr_addr),
    .sv_wr_data (sv_wr_data),
    .sv_commit  (sv_commit),
    .sv_reload  (sv_reload),
    .q_valid    (q_valid),
    .q_data     (q_data),
    .q_ready    (q_ready),
    .query      (query),
    .search_0   (search_0),
    .search_1   (search_1),
    .search_2   (search_2),
    .search_3   (search_3),
    .search_4   (search_4),
    .search_5   (search_5),
    .search_6   (search_6),
    .search_7   (search_7),
    .in_valid   (in_valid),
    .state_run  (state_run),
    .cmd_err    (cmd_err),
    .issued_cnt (issued_cnt)
  );

  assign dut_srch = {search_7, search_6, search_5, search_4,
                     search_3, search_2, search_1, search_0};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample #1 after the edge and score any issued query.
  task automatic tick();
    logic hs;
    exp_t e;
    hs = q_valid && q_ready;
    @(posedge clk);
    #1;
    if (in_valid) begin
      chk("issue_expected", wide_t'(sb.size() != 0), wide_t'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("issue_query", wide_t'(query), wide_t'(e.q));
        chk("issue_search", wide_t'(dut_srch), wide_t'(e.srch));
      end
    end
    if (hs) sb.push_back('{q: q_data, srch: model_bank});
  endtask

  task automatic load_bank(input sv_t mult);
    for (int i = 0; i < int'(NUM_SV); i++) begin
      sv_wr_en   = 1'b1;
      sv_wr_addr = SV_ADDR_W'(i);
      sv_wr_data = sv_t'(i) * mult;
      tick();
    end
    sv_wr_en  = 1'b0;
    sv_commit = 1'b1;
    tick();
    sv_commit = 1'b0;
    for (int i = 0; i < int'(NUM_SV); i++) model_bank[i] = sv_t'(i) * mult;
  endtask

  initial begin
    rst        = 1'b1;
    sv_wr_en   = 1'b0;
    sv_wr_addr = '0;
    sv_wr_data = '0;
    sv_commit  = 1'b0;
    sv_reload  = 1'b0;
    q_valid    = 1'b0;
    q_data     = '0;
    model_bank = '0;

    //          wr    addr  data              cmt   rld   run   err     rdy
    for (int i = 0; i < 7; i++)
      tbl[i] = '{1'b1, SV_ADDR_W'(i), sv_t'(i) * 64'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 3'd0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b1,    1'b0}; // incomplete commit
    tbl[8]  = '{1'b0, 3'd0, 64'h0,  1'b0, 1'b1, 1'b0, 1'b1,    1'b0}; // reload in LOAD
    tbl[9]  = '{1'b0, 3'd0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0,    1'b0}; // idle
    tbl[10] = '{1'b1, 3'd7, 64'h77, 1'b1, 1'b0, 1'b0, 1'b1,    1'b0}; // same-cycle write
    tbl[11] = '{1'b0, 3'd0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0,    1'b1}; // good commit
    tbl[12] = '{1'b1, 3'd0, 64'hBAD, 1'b0, 1'b0, 1'b1, !SHADOW, 1'b1}; // write in RUN
    tbl[13] = '{1'b0, 3'd0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1,    1'b1}; // commit in RUN
    tbl[14] = '{1'b0, 3'd0, 64'h0,  1'b0, 1'b0, 1'b1, 1'b0,    1'b1}; // idle

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", wide_t'({q_ready, in_valid, state_run, cmd_err, issued_cnt}), wide_t'(0));
    chk("reset_query", wide_t'(query), wide_t'(0));
    chk("reset_search", wide_t'(dut_srch), wide_t'(0));
    rst = 1'b0;

    // Command table.
    foreach (tbl[i]) begin
      sv_wr_en   = tbl[i].wr;
      sv_wr_addr = tbl[i].addr;
      sv_wr_data = tbl[i].data;
      sv_commit  = tbl[i].commit;
      sv_reload  = tbl[i].reload;
      tick();
      chk($sformatf("tbl%0d_state_run", i), wide_t'(state_run), wide_t'(tbl[i].e_run));
      chk($sformatf("tbl%0d_cmd_err", i), wide_t'(cmd_err), wide_t'(tbl[i].e_err));
      chk($sformatf("tbl%0d_q_ready", i), wide_t'(q_ready), wide_t'(tbl[i].e_rdy));
    end
    sv_wr_en  = 1'b0;
    sv_commit = 1'b0;
    sv_reload = 1'b0;
    for (int i = 0; i < int'(NUM_SV); i++) model_bank[i] = sv_t'(i) * 64'h11;

    // Latency of a single query.
    q_valid = 1'b1;
    q_data  = '0;
    tick();
    q_valid = 1'b0;
    chk("lat_edge_n_in_valid", wide_t'(in_valid), wide_t'(0));
    tick();
    chk("lat_edge_n1_in_valid", wide_t'(in_valid), wide_t'(1));
    chk("lat_query", wide_t'(query), wide_t'(0));
    chk("lat_search_3", wide_t'(search_3), wide_t'(64'h33));

    // Sustained streaming: q_ready held, one issue per cycle, in order.
    q_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      q_data = {$urandom, $urandom};
      chk($sformatf("stream_q_ready%0d", i), wide_t'(q_ready), wide_t'(1));
      tick();
      if (i > 0) chk($sformatf("stream_in_valid%0d", i), wide_t'(in_valid), wide_t'(1));
    end
    q_valid = 1'b0;
    tick();
    chk("stream_last_in_valid", wide_t'(in_valid), wide_t'(1));
    tick();
    chk("stream_idle_in_valid", wide_t'(in_valid), wide_t'(0));
    chk("stream_issued_cnt", wide_t'(issued_cnt), wide_t'(13));

    // Reload with a query accepted on the same edge: it still drains, then LOAD.
    q_valid   = 1'b1;
    q_data    = 64'hDEAD_BEEF_0000_0001;
    sv_reload = 1'b1;
    tick();
    q_valid   = 1'b0;
    sv_reload = 1'b0;
    chk("drain_state_run", wide_t'(state_run), wide_t'(0));
    chk("drain_q_ready", wide_t'(q_ready), wide_t'(0));
    chk("drain_cmd_err", wide_t'(cmd_err), wide_t'(0));
    tick();
    chk("drain_in_valid", wide_t'(in_valid), wide_t'(1));
    tick();
    tick();
    chk("drain_in_valid_done", wide_t'(in_valid), wide_t'(0));
    chk("drain_sb_empty", wide_t'(sb.size()), wide_t'(0));
    chk("drain_issued_cnt", wide_t'(issued_cnt), wide_t'(14));
    sv_commit = 1'b1;
    tick();
    sv_commit = 1'b0;
    chk("load_mask_cleared_err", wide_t'(cmd_err), wide_t'(1));
    chk("load_mask_cleared_run", wide_t'(state_run), wide_t'(0));

    // Reset mid-stream with queries in flight.
    load_bank(64'h22);
    chk("reload_state_run", wide_t'(state_run), wide_t'(1));
    q_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q_data = 64'h100 + sv_t'(i);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("rst_ctrl", wide_t'({q_ready, in_valid, state_run, cmd_err, issued_cnt}), wide_t'(0));
    chk("rst_query", wide_t'(query), wide_t'(0));
    chk("rst_search", wide_t'(dut_srch), wide_t'(0));
    sb.delete();
    q_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_in_valid%0d", i), wide_t'(in_valid), wide_t'(0));
    end
    sv_commit = 1'b1;
    tick();
    sv_commit = 1'b0;
    chk("post_rst_commit_err", wide_t'(cmd_err), wide_t'(1));

    // Fresh bank after reset.
    load_bank(64'h5A);
    chk("fresh_state_run", wide_t'(state_run), wide_t'(1));
    q_valid = 1'b1;
    q_data  = 64'h1234;
    tick();
    q_valid = 1'b0;
    tick();
    chk("fresh_search_7", wide_t'(search_7), wide_t'(64'h5A * 7));
    chk("fresh_issued_cnt", wide_t'(issued_cnt), wide_t'(1));

`ifdef SHADOW_BANK_EN
    // Rewrite the shadow bank while running and commit it.
    for (int i = 0; i < int'(NUM_SV); i++) begin
      sv_wr_en   = 1'b1;
      sv_wr_addr = SV_ADDR_W'(i);
      sv_wr_data = sv_t'(i) * 64'h77;
      tick();
    end
    sv_wr_en = 1'b0;
    chk("shadow_wr_no_err", wide_t'(cmd_err), wide_t'(0));
    sv_commit = 1'b1;
    tick();
    sv_commit = 1'b0;
    chk("shadow_commit_no_err", wide_t'(cmd_err), wide_t'(0));
    chk("shadow_commit_run", wide_t'(state_run), wide_t'(1));
    for (int i = 0; i < int'(NUM_SV); i++) model_bank[i] = sv_t'(i) * 64'h77;
    q_valid = 1'b1;
    q_data  = 64'h5151;
    tick();
    q_valid = 1'b0;
    tick();
    chk("shadow_search_3", wide_t'(search_3), wide_t'(64'h77 * 3));
`endif

    repeat (3) tick();
    chk("final_sb_empty", wide_t'(sb.size()), wide_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
